// File: rtl/corelet_pkg.sv
// Shared corelet types and default sizes for the psum drain path.
package corelet_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int ADDR_BW_DEF = 11;
  localparam int PSUM_VEC_W  = COL_DEF * PSUM_BW_DEF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    ACC,
    WRITE,
    DONE
  } drain_state_t;

endpackage

// File: rtl/psum_lane_adder.sv
// col parallel psum_bw-bit wrapping adders, lane0 in the LSBs; purely combinational.
module psum_lane_adder #(
  parameter int col     = 8,
  parameter int psum_bw = 16
) (
  input  logic [col*psum_bw-1:0] a,
  input  logic [col*psum_bw-1:0] b,
  output logic [col*psum_bw-1:0] sum
);

  for (genvar l = 0; l < col; l++) begin : g_lane
    // Carry out of each lane is dropped: two's complement wrap, no saturation.
    assign sum[l*psum_bw +: psum_bw] = a[l*psum_bw +: psum_bw] + b[l*psum_bw +: psum_bw];
  end

endmodule

// File: rtl/psum_drain_ctrl.sv
// OFIFO-to-psum-SRAM drain sequencer. Define DRAIN_ACC_EN to build the
// read-modify-write accumulate path (READ/ACC states and lane adders).
module psum_drain_ctrl
  import corelet_pkg::*;
#(
  parameter int col      = COL_DEF,
  parameter int psum_bw  = PSUM_BW_DEF,
  parameter int addr_bw  = ADDR_BW_DEF,
  parameter int tile_len = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic                   acc_mode,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_dout,
  output logic                   ofifo_rd,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_bw-1:0]     sram_a,
  output logic [col*psum_bw-1:0] sram_d,
  input  logic [col*psum_bw-1:0] sram_q,
  output logic                   busy,
  output logic                   done
);

  localparam int VW    = col * psum_bw;
  localparam int CNT_W = (tile_len > 1) ? $clog2(tile_len) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(tile_len - 1);

  drain_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [addr_bw-1:0] base_q, a_q;
  logic [VW-1:0]      data_q, data_d, d_q;
  logic               last;

  assign last = (cnt_q == LAST);

`ifdef DRAIN_ACC_EN
  logic          acc_q;
  logic [VW-1:0] sum;

  psum_lane_adder #(.col(col), .psum_bw(psum_bw)) u_adder (
    .a   (data_q),
    .b   (sram_q),
    .sum (sum)
  );
`else
  logic acc_q;
  logic unused_acc;
  assign acc_q      = 1'b0;
  assign unused_acc = ^{sram_q, acc_mode};
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE:  if (start) state_d = WAIT;
      WAIT:  if (ofifo_valid) begin
               data_d  = ofifo_dout;
               state_d = acc_q ? READ : WRITE;
             end
`ifdef DRAIN_ACC_EN
      READ:  state_d = ACC;
      ACC:   begin
               data_d  = sum;
               state_d = WRITE;
             end
`endif
      WRITE: state_d = last ? DONE : WAIT;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      a_q     <= '0;
      d_q     <= '0;
`ifdef DRAIN_ACC_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (state_q == IDLE && start) begin
        base_q <= base_addr;
        cnt_q  <= '0;
`ifdef DRAIN_ACC_EN
        acc_q  <= acc_mode;
`endif
      end
      if (state_q == WRITE && !last) cnt_q <= cnt_q + CNT_W'(1);
      // SRAM address/data are loaded on entry to an access state so they hold between accesses.
      if (state_d == READ || state_d == WRITE) a_q <= base_q + addr_bw'(cnt_q);
      if (state_d == WRITE) d_q <= data_d;
    end
  end

  assign ofifo_rd = reset & (state_q == WAIT) & ofifo_valid;
  assign sram_cen = !(state_q == READ || state_q == WRITE);
  assign sram_wen = !(state_q == WRITE);
  assign sram_a   = a_q;
  assign sram_d   = d_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
